// File: rtl/sum_accum.sv
// sum_accum: accumulates a programmed number of 5-bit sums from an upstream
// adder, then holds the total (with a sticky overflow flag) until the
// consumer takes it.
module sum_accum #(
    parameter int ACC_W = 10,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [4:0]       sum_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] target_reg;
    logic             overflow_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    // One extra bit on the sum exposes the carry out of the accumulator MSB.
    logic [ACC_W:0]   acc_next;
    logic [CNT_W-1:0] count_next;

    assign acc_next   = {1'b0, acc_reg} + {{(ACC_W-4){1'b0}}, sum_in};
    assign count_next = count_reg + {{(CNT_W-1){1'b0}}, 1'b1};

    // in_ready is decoded straight from the state so upstream sees it in the
    // same cycle the FSM enters ACCUM.
    assign in_ready  = (state_reg == ACCUM);
    assign acc_out   = acc_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign overflow  = overflow_reg;

    // Run control FSM: datapath and registered status outputs update together.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            count_reg     <= '0;
            target_reg    <= '0;
            overflow_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        target_reg   <= num_samples;
                        acc_reg      <= '0;
                        count_reg    <= '0;
                        overflow_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        // An empty run goes straight to presenting a zero total.
                        if (num_samples == '0) begin
                            state_reg     <= HOLD;
                            out_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_reg   <= acc_next[ACC_W-1:0];
                        count_reg <= count_next;
                        if (acc_next[ACC_W]) begin
                            overflow_reg <= 1'b1;
                        end
                        if (count_next == target_reg) begin
                            state_reg     <= HOLD;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accum.sv
// Directed testbench for sum_accum: one wide (ACC_W=10) and one narrow
// (ACC_W=8) instance share the same stimulus.
module tb_sum_accum;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  num_samples;
    logic [4:0]  sum_in;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready_w, out_valid_w, busy_w, overflow_w;
    logic [9:0]  acc_out_w;
    logic        in_ready_n, out_valid_n, busy_n, overflow_n;
    logic [7:0]  acc_out_n;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clock = ~clock;

    sum_accum #(.ACC_W(10), .CNT_W(4)) u_wide (
        .clock(clock), .reset_n(reset_n), .start(start), .num_samples(num_samples),
        .sum_in(sum_in), .in_valid(in_valid), .in_ready(in_ready_w),
        .acc_out(acc_out_w), .out_valid(out_valid_w), .out_ready(out_ready),
        .busy(busy_w), .overflow(overflow_w)
    );

    sum_accum #(.ACC_W(8), .CNT_W(4)) u_narrow (
        .clock(clock), .reset_n(reset_n), .start(start), .num_samples(num_samples),
        .sum_in(sum_in), .in_valid(in_valid), .in_ready(in_ready_n),
        .acc_out(acc_out_n), .out_valid(out_valid_n), .out_ready(out_ready),
        .busy(busy_n), .overflow(overflow_n)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; num_samples = '0; sum_in = '0;
        in_valid = 1'b0; out_ready = 1'b0;
        step(); step();
        reset_n = 1'b1;
        total_cnt++;
        if ({acc_out_w, out_valid_w, in_ready_w, busy_w, overflow_w} !== 14'd0)
            $display("FAIL reset_wide: got acc=%0d ov=%b rdy=%b busy=%b ovf=%b, expected all 0",
                     acc_out_w, out_valid_w, in_ready_w, busy_w, overflow_w);
        else pass_cnt++;
        total_cnt++;
        if ({acc_out_n, out_valid_n, in_ready_n, busy_n, overflow_n} !== 12'd0)
            $display("FAIL reset_narrow: got acc=%0d ov=%b rdy=%b busy=%b ovf=%b, expected all 0",
                     acc_out_n, out_valid_n, in_ready_n, busy_n, overflow_n);
        else pass_cnt++;
        $display("reset: acc=%0d out_valid=%b busy=%b", acc_out_w, out_valid_w, busy_w);
    endtask

    task automatic test_basic();
        logic [4:0] sums [3];
        sums[0] = 5'd5; sums[1] = 5'd31; sums[2] = 5'd0;
        start = 1'b1; num_samples = 4'd3;
        step();
        start = 1'b0;
        total_cnt++;
        if (in_ready_w !== 1'b1 || busy_w !== 1'b1 || acc_out_w !== 10'd0)
            $display("FAIL basic_enter: rdy=%b busy=%b acc=%0d, expected 1 1 0",
                     in_ready_w, busy_w, acc_out_w);
        else pass_cnt++;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sum_in = sums[i];
            step();
        end
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid_w !== 1'b1 || acc_out_w !== 10'd36 || overflow_w !== 1'b0 || in_ready_w !== 1'b0)
            $display("FAIL basic_result: ov=%b acc=%0d ovf=%b rdy=%b, expected 1 36 0 0",
                     out_valid_w, acc_out_w, overflow_w, in_ready_w);
        else pass_cnt++;
        $display("basic: 5+31+0 -> acc=%0d out_valid=%b", acc_out_w, out_valid_w);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total_cnt++;
        if (out_valid_w !== 1'b0 || busy_w !== 1'b0 || acc_out_w !== 10'd36)
            $display("FAIL basic_release: ov=%b busy=%b acc=%0d, expected 0 0 36",
                     out_valid_w, busy_w, acc_out_w);
        else pass_cnt++;
    endtask

    task automatic test_gaps();
        int gap_bad = 0;
        start = 1'b1; num_samples = 4'd4;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; sum_in = 5'd7;
            step();
            in_valid = 1'b0;
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    if (in_ready_w !== 1'b1 || acc_out_w !== 10'(7 * (i + 1))) gap_bad++;
                    step();
                end
            end
        end
        total_cnt++;
        if (gap_bad != 0)
            $display("FAIL gaps_bubble: %0d bad gap cycles, expected 0 (in_ready=1, acc steady)", gap_bad);
        else pass_cnt++;
        total_cnt++;
        if (out_valid_w !== 1'b1 || acc_out_w !== 10'd28)
            $display("FAIL gaps_result: ov=%b acc=%0d, expected 1 28", out_valid_w, acc_out_w);
        else pass_cnt++;
        $display("gaps: 4x7 with bubbles -> acc=%0d", acc_out_w);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_overflow_and_empty();
        int hold_bad = 0;
        start = 1'b1; num_samples = 4'd15;
        step();
        start = 1'b0;
        in_valid = 1'b1; sum_in = 5'd31;
        repeat (15) step();
        in_valid = 1'b0;
        total_cnt++;
        if (acc_out_w !== 10'd465 || overflow_w !== 1'b0 || out_valid_w !== 1'b1)
            $display("FAIL max_wide: acc=%0d ovf=%b ov=%b, expected 465 0 1",
                     acc_out_w, overflow_w, out_valid_w);
        else pass_cnt++;
        total_cnt++;
        if (acc_out_n !== 8'd209 || overflow_n !== 1'b1)
            $display("FAIL wrap_narrow: acc=%0d ovf=%b, expected 209 1", acc_out_n, overflow_n);
        else pass_cnt++;
        $display("overflow: wide acc=%0d ovf=%b narrow acc=%0d ovf=%b",
                 acc_out_w, overflow_w, acc_out_n, overflow_n);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total_cnt++;
        if (overflow_n !== 1'b1 || out_valid_n !== 1'b0)
            $display("FAIL ovf_sticky_idle: ovf=%b ov=%b, expected 1 0", overflow_n, out_valid_n);
        else pass_cnt++;
        // Empty run: straight to HOLD with a zero total, overflow cleared.
        start = 1'b1; num_samples = 4'd0;
        step();
        start = 1'b0;
        total_cnt++;
        if (out_valid_w !== 1'b1 || acc_out_w !== 10'd0 || busy_w !== 1'b1 || overflow_n !== 1'b0)
            $display("FAIL empty_hold: ov=%b acc=%0d busy=%b ovf_n=%b, expected 1 0 1 0",
                     out_valid_w, acc_out_w, busy_w, overflow_n);
        else pass_cnt++;
        repeat (5) begin
            step();
            if (out_valid_w !== 1'b1 || acc_out_w !== 10'd0) hold_bad++;
        end
        total_cnt++;
        if (hold_bad != 0)
            $display("FAIL empty_stall: %0d bad stall cycles, expected 0", hold_bad);
        else pass_cnt++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total_cnt++;
        if (busy_w !== 1'b0 || out_valid_w !== 1'b0)
            $display("FAIL empty_release: busy=%b ov=%b, expected 0 0", busy_w, out_valid_w);
        else pass_cnt++;
        $display("empty: released, busy=%b", busy_w);
    endtask

    task automatic test_reset_midrun();
        start = 1'b1; num_samples = 4'd5;
        step();
        start = 1'b0;
        in_valid = 1'b1; sum_in = 5'd3;
        repeat (2) step();
        in_valid = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        total_cnt++;
        if ({acc_out_w, out_valid_w, in_ready_w, busy_w, overflow_w} !== 14'd0)
            $display("FAIL midrun_reset: acc=%0d ov=%b rdy=%b busy=%b ovf=%b, expected all 0",
                     acc_out_w, out_valid_w, in_ready_w, busy_w, overflow_w);
        else pass_cnt++;
        start = 1'b1; num_samples = 4'd1;
        step();
        start = 1'b0;
        in_valid = 1'b1; sum_in = 5'd9;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (acc_out_w !== 10'd9 || out_valid_w !== 1'b1)
            $display("FAIL midrun_restart: acc=%0d ov=%b, expected 9 1", acc_out_w, out_valid_w);
        else pass_cnt++;
        $display("midrun reset: restart acc=%0d", acc_out_w);
    endtask

    // Entered while still in HOLD from the previous run (acc=9).
    task automatic test_hold_ignore();
        int bad = 0;
        for (int i = 0; i < 4; i++) begin
            start = (i % 2 == 0); num_samples = 4'd2;
            in_valid = (i % 2 == 1); sum_in = 5'd20;
            step();
            if (acc_out_w !== 10'd9 || out_valid_w !== 1'b1 || in_ready_w !== 1'b0) bad++;
        end
        start = 1'b0; in_valid = 1'b0;
        total_cnt++;
        if (bad != 0)
            $display("FAIL hold_ignore: %0d bad cycles, expected 0 (acc=9 held)", bad);
        else pass_cnt++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        // in_valid in IDLE must not disturb the retained result.
        in_valid = 1'b1; sum_in = 5'd5;
        repeat (2) step();
        in_valid = 1'b0;
        total_cnt++;
        if (acc_out_w !== 10'd9 || busy_w !== 1'b0 || in_ready_w !== 1'b0)
            $display("FAIL idle_ignore: acc=%0d busy=%b rdy=%b, expected 9 0 0",
                     acc_out_w, busy_w, in_ready_w);
        else pass_cnt++;
        $display("hold/idle ignore: acc=%0d", acc_out_w);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overflow_and_empty();
        test_reset_midrun();
        test_hold_ignore();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
